conv_layer_engine: RTL and testbench
====================================

CONV_LAYER_ENGINE -- requirements
Module: conv_layer_engine

Interface
REQ-001 Parameter IN_CH, default 1: input channels.
REQ-002 Parameter OUT_CH, default 16: filters / output channels.
REQ-003 Parameter IN_H, default 28: input rows. Parameter IN_W, default 28: input columns.
REQ-004 Parameter K, default 3: square kernel size; OH=IN_H-K+1, OW=IN_W-K+1; stride 1, no padding.
REQ-005 Parameter DW, default 8: signed pixel/weight width. Parameter AW, default 32: signed bias/accumulator/output width.
REQ-006 Parameter RELU, default 1: 1 enables ReLU. Parameter SHIFT, default 0: arithmetic right shift applied to the result.
REQ-007 clk  in  1  clock; all state changes on rising edge.
REQ-008 reset  in  1  reset, asynchronous, active-high.
REQ-009 start  in  1  begin one full layer pass; sampled only in IDLE.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse after the last output is accepted.
REQ-012 img_addr  out  clog2(IN_CH*IN_H*IN_W)  pixel address = (c*IN_H+row)*IN_W+col.
REQ-013 img_rdata  in  DW  signed pixel; valid exactly one cycle after img_addr is presented.
REQ-014 wt_addr  out  clog2(OUT_CH*IN_CH*K*K)  weight address = ((f*IN_CH+c)*K+m)*K+n.
REQ-015 wt_rdata  in  DW  signed weight; one-cycle read latency.
REQ-016 bias_addr  out  clog2(OUT_CH)  bias address = f. bias_rdata  in  AW  signed; one-cycle latency.
REQ-017 out_valid  out  1; out_ready  in  1; out_data  out  AW  signed result; out_f, out_row, out_col  out  index widths: result coordinates.

Function
REQ-018 Iteration order SHALL be f (outer), row, col, then c, m, n (inner); one MAC per cycle.
REQ-019 FSM states SHALL be IDLE, BIAS, MAC, DRAIN, OUT, DONE.
REQ-020 IDLE->BIAS on start; BIAS presents bias_addr=f for one cycle.
REQ-021 MAC presents one (img_addr, wt_addr) pair per cycle for N=IN_CH*K*K cycles; the accumulator loads bias_rdata on the first MAC cycle and adds each returned product one cycle after its address.
REQ-022 DRAIN adds the final product, then enters OUT.
REQ-023 Products SHALL be full-precision DW x DW signed, sign-extended to AW; accumulation wraps modulo 2^AW.
REQ-024 Result = acc >>> SHIFT, then forced to 0 if RELU=1 and negative; registered into out_data on entry to OUT.
REQ-025 OUT holds out_valid=1 and stable out_data/out_f/out_row/out_col until out_ready=1; the transfer completes on a clk edge with both high.
REQ-026 After transfer, indices advance (col, then row, then f); the next state is BIAS, or DONE if (f,row,col)=(OUT_CH-1,OH-1,OW-1).
REQ-027 With out_ready held high, each output SHALL take exactly N+3 cycles, from BIAS entry to the transfer edge.
REQ-028 DONE lasts one cycle with done=1, then returns to IDLE; start in DONE is ignored.
REQ-029 start while busy=1 SHALL be ignored; all indices zero on IDLE->BIAS.
REQ-030 Address outputs outside BIAS/MAC are don't-care but SHALL remain in range.

Reset
REQ-031 reset=1 SHALL immediately force IDLE, with busy=0, done=0, out_valid=0, out_data=0, indices 0, accumulator 0.
REQ-032 Reset mid-pass SHALL abort without a done pulse; the next start restarts from (0,0,0).

Verification
REQ-033 Default params, all pixels=1, all weights=1, biases=0, out_ready=1 -> 16*26*26=10816 outputs, each 9; done one cycle after the last transfer.
REQ-034 Weight=-1 everywhere, bias=5, pixels=1 -> out_data=0 with RELU=1 and -4 with RELU=0.
REQ-035 IN_CH=2, K=2, IN_H=IN_W=3, OUT_CH=1; ch0 pixels=2, ch1 pixels=3, weights=1, bias=1 -> four outputs of 21, each N+3=11 cycles apart.
REQ-036 out_ready low for 5 cycles during OUT -> out_valid stays high, data/indices stable, no address activity; advances when ready rises.
REQ-037 reset asserted during MAC of output (3,10,4) -> busy=0 and out_valid=0 in the same cycle, no done; a new start emits (0,0,0) first.
REQ-038 SHIFT=2, pixels=10, weights=1, bias=3, K=3 -> out_data=(90+3)>>>2=23.

Source files
------------

// File: rtl/conv_layer_engine_if.sv
// Bus bundle for conv_layer_engine: control handshake, the three memory
// read ports and the result stream. master = engine side, slave = environment.
interface conv_layer_engine_if #(
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 16,
  parameter int IN_H   = 28,
  parameter int IN_W   = 28,
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int AW     = 32
);
  localparam int OH     = IN_H - K + 1;
  localparam int OW     = IN_W - K + 1;
  localparam int IMG_AW = (IN_CH * IN_H * IN_W > 1) ? $clog2(IN_CH * IN_H * IN_W) : 1;
  localparam int WT_AW  = (OUT_CH * IN_CH * K * K > 1) ? $clog2(OUT_CH * IN_CH * K * K) : 1;
  localparam int F_W    = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int ROW_W  = (OH > 1) ? $clog2(OH) : 1;
  localparam int COL_W  = (OW > 1) ? $clog2(OW) : 1;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [IMG_AW-1:0]        img_addr;
  logic signed [DW-1:0]     img_rdata;
  logic [WT_AW-1:0]         wt_addr;
  logic signed [DW-1:0]     wt_rdata;
  logic [F_W-1:0]           bias_addr;
  logic signed [AW-1:0]     bias_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [AW-1:0]     out_data;
  logic [F_W-1:0]           out_f;
  logic [ROW_W-1:0]         out_row;
  logic [COL_W-1:0]         out_col;

  modport master (
    input  start, img_rdata, wt_rdata, bias_rdata, out_ready,
    output busy, done, img_addr, wt_addr, bias_addr,
    output out_valid, out_data, out_f, out_row, out_col
  );

  modport slave (
    output start, img_rdata, wt_rdata, bias_rdata, out_ready,
    input  busy, done, img_addr, wt_addr, bias_addr,
    input  out_valid, out_data, out_f, out_row, out_col
  );
endinterface

// File: rtl/conv_layer_engine.sv
// Single-MAC convolution layer engine: stride 1, no padding, optional
// arithmetic shift and ReLU on each result, ready/valid result stream.
//
// state | meaning
// IDLE  | waiting for start; all indices parked at zero
// BIAS  | bias_addr = f presented; MAC counters cleared
// MAC   | one (pixel, weight) address pair per cycle, N cycles
// DRAIN | last product added; shifted/ReLU result captured
// OUT   | out_valid held until out_ready; then step (col,row,f)
// DONE  | one-cycle done pulse, back to IDLE
module conv_layer_engine #(
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 16,
  parameter int IN_H   = 28,
  parameter int IN_W   = 28,
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int AW     = 32,
  parameter int RELU   = 1,
  parameter int SHIFT  = 0
) (
  input logic clk,
  input logic reset,
  conv_layer_engine_if.master bus
);
  localparam int OH     = IN_H - K + 1;
  localparam int OW     = IN_W - K + 1;
  localparam int N      = IN_CH * K * K;
  localparam int IMG_AW = (IN_CH * IN_H * IN_W > 1) ? $clog2(IN_CH * IN_H * IN_W) : 1;
  localparam int WT_AW  = (OUT_CH * IN_CH * K * K > 1) ? $clog2(OUT_CH * IN_CH * K * K) : 1;
  localparam int F_W    = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int ROW_W  = (OH > 1) ? $clog2(OH) : 1;
  localparam int COL_W  = (OW > 1) ? $clog2(OW) : 1;
  localparam int CH_W   = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int K_W    = (K > 1) ? $clog2(K) : 1;
  localparam int N_W    = (N > 1) ? $clog2(N) : 1;

  localparam logic [F_W-1:0]   F_LAST   = F_W'(OUT_CH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OH - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OW - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(IN_CH - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(K - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'(N - 1);

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, OUT, DONE} state_t;

  state_t                state;
  logic [F_W-1:0]        f;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic [CH_W-1:0]       ch;
  logic [K_W-1:0]        m;
  logic [K_W-1:0]        n;
  logic [N_W-1:0]        mac_left;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  out_data_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  out_valid_reg;

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   acc_sum;
  logic signed [AW-1:0]   shifted;
  logic signed [AW-1:0]   result;
  logic                   last_out;

  // Counters are always in range, so addresses stay legal in every state.
  assign bus.img_addr  = IMG_AW'((int'(ch) * IN_H + int'(row) + int'(m)) * IN_W + int'(col) + int'(n));
  assign bus.wt_addr   = WT_AW'(((int'(f) * IN_CH + int'(ch)) * K + int'(m)) * K + int'(n));
  assign bus.bias_addr = f;

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_f     = f;
  assign bus.out_row   = row;
  assign bus.out_col   = col;

  assign prod     = (2*DW)'(bus.img_rdata) * (2*DW)'(bus.wt_rdata);
  assign prod_ext = AW'(prod);
  assign acc_sum  = acc + prod_ext;
  assign shifted  = acc_sum >>> SHIFT;
  assign result   = (RELU != 0 && shifted[AW-1]) ? '0 : shifted;
  assign last_out = (f == F_LAST) && (row == ROW_LAST) && (col == COL_LAST);

  // Sequencer: state, loop counters, accumulator and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      f             <= '0;
      row           <= '0;
      col           <= '0;
      ch            <= '0;
      m             <= '0;
      n             <= '0;
      mac_left      <= '0;
      acc           <= '0;
      out_data_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= BIAS;
            busy_reg <= 1'b1;
            f        <= '0;
            row      <= '0;
            col      <= '0;
          end
        end
        BIAS: begin
          state    <= MAC;
          ch       <= '0;
          m        <= '0;
          n        <= '0;
          mac_left <= N_LAST;
        end
        MAC: begin
          // Bias arrives on the first MAC cycle; products trail their address by one cycle.
          if (mac_left == N_LAST) acc <= bus.bias_rdata;
          else                    acc <= acc_sum;
          if (n == K_LAST) begin
            n <= '0;
            if (m == K_LAST) begin
              m  <= '0;
              ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
            end else begin
              m <= m + 1'b1;
            end
          end else begin
            n <= n + 1'b1;
          end
          if (mac_left == '0) state <= DRAIN;
          else                mac_left <= mac_left - 1'b1;
        end
        DRAIN: begin
          acc           <= acc_sum;
          out_data_reg  <= result;
          out_valid_reg <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            if (last_out) begin
              state    <= DONE;
              done_reg <= 1'b1;
              f        <= '0;
              row      <= '0;
              col      <= '0;
            end else begin
              state <= BIAS;
              if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                  row <= '0;
                  f   <= f + 1'b1;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv_layer_engine.sv
// Bench for conv_layer_engine: two engines on one small geometry, one with
// ReLU and no shift, one without ReLU and SHIFT=2, fed from shared memories.
module tb_conv_layer_engine;
  localparam int IN_CH = 2, OUT_CH = 2, IN_H = 3, IN_W = 4, K = 2, DW = 8, AW = 32;
  localparam int OH = IN_H - K + 1, OW = IN_W - K + 1, N = IN_CH * K * K;

  typedef struct { int p0; int p1; int w; int b; longint ea; longint eb; } vec_t;
  typedef struct { int f; int r; int c; longint d; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  logic signed [DW-1:0] img_mem  [IN_CH*IN_H*IN_W];
  logic signed [DW-1:0] wt_mem   [OUT_CH*IN_CH*K*K];
  logic signed [AW-1:0] bias_mem [OUT_CH];

  vec_t vecs[6];
  exp_t qa[$];
  exp_t qb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   done_cnt[2] = '{0, 0};
  int   last_xfer[2] = '{0, 0};
  bit   timing_on = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_layer_engine_if #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .IN_H(IN_H), .IN_W(IN_W), .K(K), .DW(DW), .AW(AW)) ia ();
  conv_layer_engine_if #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .IN_H(IN_H), .IN_W(IN_W), .K(K), .DW(DW), .AW(AW)) ib ();

  conv_layer_engine #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .IN_H(IN_H), .IN_W(IN_W), .K(K), .DW(DW), .AW(AW),
                      .RELU(1), .SHIFT(0)) ua (.clk(clk), .reset(reset), .bus(ia));
  conv_layer_engine #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .IN_H(IN_H), .IN_W(IN_W), .K(K), .DW(DW), .AW(AW),
                      .RELU(0), .SHIFT(2)) ub (.clk(clk), .reset(reset), .bus(ib));

  // One-cycle-latency memories behind each engine.
  always @(posedge clk) begin
    ia.img_rdata  <= img_mem[int'(ia.img_addr)];
    ia.wt_rdata   <= wt_mem[int'(ia.wt_addr)];
    ia.bias_rdata <= bias_mem[int'(ia.bias_addr)];
    ib.img_rdata  <= img_mem[int'(ib.img_addr)];
    ib.wt_rdata   <= wt_mem[int'(ib.wt_addr)];
    ib.bias_rdata <= bias_mem[int'(ib.bias_addr)];
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fill_const(input int p0, input int p1, input int w, input int b);
    for (int c = 0; c < IN_CH; c++)
      for (int i = 0; i < IN_H*IN_W; i++) img_mem[c*IN_H*IN_W + i] = DW'((c == 0) ? p0 : p1);
    for (int i = 0; i < OUT_CH*IN_CH*K*K; i++) wt_mem[i] = DW'(w);
    for (int i = 0; i < OUT_CH; i++) bias_mem[i] = AW'(b);
  endtask

  task automatic fill_rand();
    int t;
    for (int i = 0; i < IN_CH*IN_H*IN_W; i++) img_mem[i] = DW'($urandom_range(255));
    for (int i = 0; i < OUT_CH*IN_CH*K*K; i++) wt_mem[i] = DW'($urandom_range(255));
    for (int i = 0; i < OUT_CH; i++) begin
      t = int'($urandom_range(2000)) - 1000;
      bias_mem[i] = AW'(t);
    end
  endtask

  // Straight reference convolution over the bench's own memory arrays.
  function automatic longint ref_conv(input int f, input int r, input int c);
    longint s;
    s = bias_mem[f];
    for (int ch = 0; ch < IN_CH; ch++)
      for (int m = 0; m < K; m++)
        for (int n = 0; n < K; n++)
          s += img_mem[(ch*IN_H + r + m)*IN_W + c + n] * wt_mem[((f*IN_CH + ch)*K + m)*K + n];
    return s;
  endfunction

  task automatic push_expected(input bit use_const, input longint ea, input longint eb);
    exp_t e;
    longint s;
    for (int f = 0; f < OUT_CH; f++)
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++) begin
          e.f = f; e.r = r; e.c = c;
          s = ref_conv(f, r, c);
          e.d = use_const ? ea : ((s < 0) ? 0 : s);
          qa.push_back(e);
          e.d = use_const ? eb : (s >>> 2);
          qb.push_back(e);
        end
  endtask

  task automatic check_xfer(input int which, input longint d, input int f, input int r, input int c);
    exp_t  e;
    string p;
    p = (which == 0) ? "a" : "b";
    if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) begin
      n_total++;
      $display("FAIL %s_unexpected_output: got (%0d,%0d,%0d) data %0d, expected no output", p, f, r, c, d);
      return;
    end
    if (which == 0) e = qa.pop_front();
    else            e = qb.pop_front();
    check({p, "_out_data"}, d, e.d);
    check({p, "_out_index"}, f*10000 + r*100 + c, e.f*10000 + e.r*100 + e.c);
    if (timing_on) check({p, "_xfer_spacing"}, cyc + 1 - last_xfer[which], N + 3);
    last_xfer[which] = cyc + 1;
  endtask

  task automatic monitor_step();
    if (!reset) begin
      if (ia.out_valid && ia.out_ready) check_xfer(0, ia.out_data, ia.out_f, ia.out_row, ia.out_col);
      if (ib.out_valid && ib.out_ready) check_xfer(1, ib.out_data, ib.out_f, ib.out_row, ib.out_col);
      if (ia.done) begin
        done_cnt[0]++;
        check("a_done_after_last", cyc - last_xfer[0], 0);
        check("a_done_queue_empty", qa.size(), 0);
      end
      if (ib.done) begin
        done_cnt[1]++;
        check("b_done_after_last", cyc - last_xfer[1], 0);
        check("b_done_queue_empty", qb.size(), 0);
      end
    end
  endtask

  task automatic check_reset_state();
    check("a_rst_ctrl", {ia.busy, ia.done, ia.out_valid}, 0);
    check("a_rst_data", ia.out_data, 0);
    check("a_rst_idx", {ia.out_f, ia.out_row, ia.out_col}, 0);
    check("b_rst_ctrl", {ib.busy, ib.done, ib.out_valid}, 0);
    check("b_rst_data", ib.out_data, 0);
    check("b_rst_idx", {ib.out_f, ib.out_row, ib.out_col}, 0);
  endtask

  task automatic kick_start();
    @(posedge clk); #1; ia.start = 1'b1; ib.start = 1'b1;
    @(posedge clk); #1; ia.start = 1'b0; ib.start = 1'b0;
    last_xfer[0] = cyc; last_xfer[1] = cyc;
  endtask

  task automatic run_pass(input bit stall);
    int     lim;
    int     d0;
    int     d1;
    longint sd;
    int     sidx;
    int     saddr;
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    ia.out_ready = !stall; ib.out_ready = !stall;
    timing_on = !stall;
    kick_start();
    // start pulses while busy must not restart the pass
    repeat (3) @(posedge clk); #1; ia.start = 1'b1; ib.start = 1'b1;
    repeat (3) @(posedge clk); #1; ia.start = 1'b0; ib.start = 1'b0;
    if (stall) begin
      lim = 0;
      while (!ia.out_valid && lim < 200) begin @(negedge clk); lim++; end
      check("stall_valid_seen", ia.out_valid, 1);
      sd    = ia.out_data;
      sidx  = {ia.out_f, ia.out_row, ia.out_col};
      saddr = {ia.img_addr, ia.wt_addr, ia.bias_addr};
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("stall_valid_held", ia.out_valid & ib.out_valid, 1);
        check("stall_data_stable", ia.out_data, sd);
        check("stall_index_stable", {ia.out_f, ia.out_row, ia.out_col}, sidx);
        check("stall_addr_stable", {ia.img_addr, ia.wt_addr, ia.bias_addr}, saddr);
      end
      @(posedge clk); #1; ia.out_ready = 1'b1; ib.out_ready = 1'b1;
    end
    lim = 0;
    while (!ia.done && lim < 3000) begin @(negedge clk); lim++; end
    check("a_done_seen", ia.done, 1);
    check("b_done_seen", ib.done, 1);
    // start raised during DONE must be ignored
    ia.start = 1'b1; ib.start = 1'b1;
    @(posedge clk); #1; ia.start = 1'b0; ib.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_done", ia.busy | ib.busy, 0);
    end
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    check("a_done_pulses", done_cnt[0] - d0, 1);
    check("b_done_pulses", done_cnt[1] - d1, 1);
  endtask

  initial begin
    int lim;
    int d0;
    //          p0    p1    w     b     relu    shift2
    vecs[0] = '{2,    3,    1,    1,    21,     5};
    vecs[1] = '{1,    1,    -1,   5,    0,      -1};
    vecs[2] = '{10,   10,   1,    3,    83,     20};
    vecs[3] = '{-128, -128, -128, 0,    131072, 32768};
    vecs[4] = '{127,  0,    127,  -100, 64416,  16104};
    vecs[5] = '{0,    0,    0,    -7,   0,      -2};

    ia.start = 1'b0; ib.start = 1'b0;
    ia.out_ready = 1'b1; ib.out_ready = 1'b1;
    fill_const(0, 0, 0, 0);
    fork
      forever begin @(negedge clk); monitor_step(); end
    join_none

    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fill_const(vecs[i].p0, vecs[i].p1, vecs[i].w, vecs[i].b);
      push_expected(1'b1, vecs[i].ea, vecs[i].eb);
      run_pass(i == 2);
    end

    repeat (2) begin
      fill_rand();
      push_expected(1'b0, 0, 0);
      run_pass(1'b0);
    end

    // Abort during the MAC phase of output (1,1,0), then restart cleanly.
    fill_const(2, 3, 1, 1);
    push_expected(1'b1, 21, 5);
    ia.out_ready = 1'b1; ib.out_ready = 1'b1;
    timing_on = 1'b1;
    kick_start();
    lim = 0;
    while (!(ia.out_f == 1 && ia.out_row == 1 && ia.out_col == 0) && lim < 500) begin
      @(negedge clk); lim++;
    end
    check("abort_target_idx", ia.out_f*100 + ia.out_row*10 + ia.out_col, 110);
    repeat (3) @(negedge clk);
    check("abort_busy_before", ia.busy & ib.busy, 1);
    d0 = done_cnt[0] + done_cnt[1];
    #1 reset = 1'b1;
    #1 check_reset_state();
    qa.delete();
    qb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_done", done_cnt[0] + done_cnt[1] - d0, 0);
    fill_const(vecs[0].p0, vecs[0].p1, vecs[0].w, vecs[0].b);
    push_expected(1'b1, vecs[0].ea, vecs[0].eb);
    run_pass(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
